// File: rtl/fan_speed_ctrl.sv
// fan_speed_ctrl: fan level scheduler with hysteresis, minimum dwell and frame-aligned PWM.
// Define FAN_CTRL_STALE_WDT_EN to enable the stale-temperature watchdog that drives fault.
module fan_speed_ctrl #(
  parameter int unsigned T_LOW        = 25,
  parameter int unsigned T_MID        = 30,
  parameter int unsigned T_HIGH       = 35,
  parameter int unsigned HYST         = 2,
  parameter int unsigned MIN_DWELL    = 1000,
  parameter int unsigned PWM_PERIOD   = 256,
  parameter int unsigned STALE_CYCLES = 100000
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic       temp_valid,
  input  logic [7:0] temperatura,
  input  logic       presencia_s,
  input  logic       motor_s,
  output logic [1:0] level,
  output logic       pwm_out,
  output logic       fault
);

  localparam logic [1:0] S_OFF  = 2'd0;
  localparam logic [1:0] S_LOW  = 2'd1;
  localparam logic [1:0] S_MID  = 2'd2;
  localparam logic [1:0] S_HIGH = 2'd3;

  localparam int unsigned DW = $clog2(MIN_DWELL + 1);
  localparam int unsigned CW = $clog2(PWM_PERIOD);

  localparam logic [DW-1:0] DWELL_MAX = DW'(MIN_DWELL);
  localparam logic [CW-1:0] CNT_LAST  = CW'(PWM_PERIOD - 1);
  localparam logic [CW:0]   DUTY_LOW  = (CW + 1)'(PWM_PERIOD / 4);
  localparam logic [CW:0]   DUTY_MID  = (CW + 1)'(PWM_PERIOD / 2);
  localparam logic [CW:0]   DUTY_HIGH = (CW + 1)'(PWM_PERIOD);
  localparam logic [7:0]    THR_LOW   = 8'(T_LOW);
  localparam logic [7:0]    THR_MID   = 8'(T_MID);
  localparam logic [7:0]    THR_HIGH  = 8'(T_HIGH);
  localparam logic [8:0]    HYST_W    = 9'(HYST);

  if (PWM_PERIOD < 4 || (PWM_PERIOD % 4) != 0 || MIN_DWELL < 1 || STALE_CYCLES < 1) begin : g_param_check
    $error("fan_speed_ctrl: invalid parameter set");
  end

  logic [7:0]        r_temp_q;
  logic [1:0]        r_level;
  logic [DW-1:0]     r_dwell;
  logic [CW-1:0]     r_pwm_cnt;
  logic [CW:0]       r_duty;
  logic              r_pwm;

  logic [1:0]        w_target;
  logic [7:0]        w_thr;
  logic signed [8:0] w_thr_hyst;
  logic              w_below_hyst;
  logic [1:0]        w_level_nx;
  logic [DW-1:0]     w_dwell_nx;
  logic [CW:0]       w_duty_nx;
  logic              w_fault;

`ifdef FAN_CTRL_STALE_WDT_EN
  localparam int unsigned SW = $clog2(STALE_CYCLES + 1);
  localparam logic [SW-1:0] STALE_MAX = SW'(STALE_CYCLES);

  logic [SW-1:0] r_stale;

  always_ff @(posedge CLK) begin
    if (Reset || temp_valid) begin
      r_stale <= '0;
    end else if (r_stale != STALE_MAX) begin
      r_stale <= r_stale + 1'b1;
    end
  end

  assign w_fault = (r_stale == STALE_MAX);
`else
  assign w_fault = 1'b0;
`endif

  always_comb begin
    w_target = S_OFF;
    if (r_temp_q >= THR_HIGH) begin
      w_target = S_HIGH;
    end else if (r_temp_q >= THR_MID) begin
      w_target = S_MID;
    end else if (r_temp_q >= THR_LOW) begin
      w_target = S_LOW;
    end
  end

  always_comb begin
    w_thr = '0;
    case (r_level)
      S_LOW:   w_thr = THR_LOW;
      S_MID:   w_thr = THR_MID;
      S_HIGH:  w_thr = THR_HIGH;
      default: w_thr = '0;
    endcase
  end

  // Signed 9-bit compare: a negative thr-HYST behaves as a floor of 0 instead of wrapping.
  assign w_thr_hyst   = $signed({1'b0, w_thr}) - $signed(HYST_W);
  assign w_below_hyst = $signed({1'b0, r_temp_q}) < w_thr_hyst;

  always_comb begin
    w_level_nx = r_level;
    w_dwell_nx = r_dwell;
    if (motor_s || w_fault) begin
      w_level_nx = S_HIGH;
      w_dwell_nx = '0;
    end else if (!presencia_s) begin
      w_level_nx = S_OFF;
      w_dwell_nx = '0;
    end else if (w_target > r_level) begin
      w_level_nx = w_target;
      w_dwell_nx = '0;
    end else if (w_target < r_level && r_dwell >= DWELL_MAX && w_below_hyst) begin
      w_level_nx = r_level - 2'd1;
      w_dwell_nx = '0;
    end else if (r_dwell != DWELL_MAX) begin
      w_dwell_nx = r_dwell + 1'b1;
    end
  end

  always_comb begin
    w_duty_nx = '0;
    case (r_level)
      S_LOW:   w_duty_nx = DUTY_LOW;
      S_MID:   w_duty_nx = DUTY_MID;
      S_HIGH:  w_duty_nx = DUTY_HIGH;
      default: w_duty_nx = '0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_temp_q  <= '0;
      r_level   <= S_OFF;
      r_dwell   <= '0;
      r_pwm_cnt <= '0;
      r_duty    <= '0;
      r_pwm     <= 1'b0;
    end else begin
      if (temp_valid) begin
        r_temp_q <= temperatura;
      end
      r_level <= w_level_nx;
      r_dwell <= w_dwell_nx;
      // Duty only changes at the frame boundary so a level change never cuts a pulse short.
      if (r_pwm_cnt == CNT_LAST) begin
        r_pwm_cnt <= '0;
        r_duty    <= w_duty_nx;
      end else begin
        r_pwm_cnt <= r_pwm_cnt + 1'b1;
      end
      r_pwm <= ({1'b0, r_pwm_cnt} < r_duty);
    end
  end

  assign level   = r_level;
  assign pwm_out = r_pwm;
  assign fault   = w_fault;

endmodule

// File: tb/tb_fan_speed_ctrl.sv
// tb_fan_speed_ctrl: table of settled-level vectors plus hand sequences for latency,
// dwell, overrides, frame-aligned duty changes, reset and the stale watchdog.
module tb_fan_speed_ctrl;

  localparam int SETTLE = 32;

  logic       CLK = 1'b0;
  logic       Reset = 1'b1;
  logic       temp_valid = 1'b0;
  logic [7:0] temperatura = '0;
  logic       presencia_s = 1'b0;
  logic       motor_s = 1'b0;
  logic [1:0] level;
  logic       pwm_out;
  logic       fault;

  int n_checks = 0;
  int n_fail = 0;
  bit ka_en = 1'b1;
  int ka_cnt = 0;

  typedef struct { int temp; bit pres; bit mot; int lvl; } vec_t;
  typedef struct { int idx; int lvl; int highs; } exp_t;

  vec_t vecs [18];
  exp_t sb [$];

  fan_speed_ctrl #(
    .T_LOW(25), .T_MID(30), .T_HIGH(35), .HYST(2),
    .MIN_DWELL(4), .PWM_PERIOD(8), .STALE_CYCLES(16)
  ) dut (
    .CLK(CLK), .Reset(Reset), .temp_valid(temp_valid), .temperatura(temperatura),
    .presencia_s(presencia_s), .motor_s(motor_s),
    .level(level), .pwm_out(pwm_out), .fault(fault)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "timeout");
  end

  // Keep-alive re-strobes the current temperature every 8 cycles so the watchdog stays quiet.
  task automatic step();
    if (ka_en && ka_cnt == 7) temp_valid = 1'b1;
    @(posedge CLK);
    #1;
    temp_valid = 1'b0;
    ka_cnt = (ka_cnt == 7) ? 0 : ka_cnt + 1;
  endtask

  task automatic strobe(input int t);
    temperatura = 8'(t);
    temp_valid = 1'b1;
    step();
  endtask

  task automatic chk(input string name, input int act, input int exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  task automatic count_highs(output int n);
    n = 0;
    repeat (8) begin
      step();
      n += int'(pwm_out);
    end
  endtask

  function automatic int highs_for(input int lvl);
    case (lvl)
      1: return 2;
      2: return 4;
      3: return 8;
      default: return 0;
    endcase
  endfunction

  initial begin
    int h;
    int dexp [15];
    int mexp [16];
    int samp [16];
    bit found;
    bit prev;
    exp_t e;

    vecs = '{
      '{36, 1'b1, 1'b0, 3}, '{34, 1'b1, 1'b0, 3}, '{32, 1'b1, 1'b0, 2}, '{28, 1'b1, 1'b0, 2},
      '{27, 1'b1, 1'b0, 1}, '{23, 1'b1, 1'b0, 1}, '{22, 1'b1, 1'b0, 0}, '{25, 1'b1, 1'b0, 1},
      '{30, 1'b1, 1'b0, 2}, '{35, 1'b1, 1'b0, 3}, '{10, 1'b1, 1'b0, 0}, '{40, 1'b0, 1'b0, 0},
      '{40, 1'b0, 1'b1, 3}, '{0,  1'b1, 1'b0, 0}, '{99, 1'b1, 1'b0, 3}, '{29, 1'b1, 1'b0, 2},
      '{0,  1'b0, 1'b0, 0}, '{29, 1'b1, 1'b0, 1}
    };
    dexp = '{3, 3, 3, 3, 2, 2, 2, 2, 2, 1, 1, 1, 1, 1, 0};
    mexp = '{1, 1, 1, 1, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1};

    // Reset state
    repeat (3) step();
    chk("reset_level", int'(level), 0);
    chk("reset_pwm", int'(pwm_out), 0);
    chk("reset_fault", int'(fault), 0);
    Reset = 1'b0;
    presencia_s = 1'b1;

    // Strobe -> temp_q one cycle later -> level the cycle after
    strobe(36);
    chk("lat_n1_level", int'(level), 0);
    step();
    chk("lat_n2_level", int'(level), 3);
    repeat (9) step();
    count_highs(h);
    chk("high_frame_highs", h, 8);

    // Hysteresis and dwell on the way down
    repeat (4) step();
    strobe(34);
    repeat (8) step();
    chk("hyst_hold_high", int'(level), 3);
    strobe(32);
    step();
    chk("dwell_to_mid", int'(level), 2);
    strobe(27);
    chk("dwell_guard0", int'(level), 2);
    for (int i = 1; i <= 3; i++) begin
      step();
      chk($sformatf("dwell_guard%0d", i), int'(level), 2);
    end
    step();
    chk("dwell_to_low", int'(level), 1);

    // Presence drop and restore
    strobe(26);
    repeat (SETTLE) step();
    chk("pres_low", int'(level), 1);
    presencia_s = 1'b0;
    step();
    chk("pres_off_level", int'(level), 0);
    repeat (9) step();
    count_highs(h);
    chk("pres_off_highs", h, 0);
    presencia_s = 1'b1;
    step();
    chk("pres_restore", int'(level), 1);

    // Motor override pulse, then stepwise descent
    strobe(20);
    repeat (SETTLE) step();
    chk("motor_pre_off", int'(level), 0);
    motor_s = 1'b1;
    step();
    chk("motor_immediate", int'(level), 3);
    step();
    step();
    motor_s = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step();
      chk($sformatf("motor_desc%0d", i), int'(level), dexp[i]);
    end

    // MID -> HIGH mid-frame: current frame keeps 4/8, next is 8/8
    strobe(31);
    repeat (SETTLE) step();
    chk("mf_pre_mid", int'(level), 2);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      prev = pwm_out;
      step();
      if (!prev && pwm_out) found = 1'b1;
    end
    chk("mf_rise_found", int'(found), 1);
    samp[0] = int'(pwm_out);
    step();
    samp[1] = int'(pwm_out);
    motor_s = 1'b1;
    for (int i = 2; i < 16; i++) begin
      step();
      samp[i] = int'(pwm_out);
    end
    for (int i = 0; i < 16; i++) chk($sformatf("mf_pwm%0d", i), samp[i], mexp[i]);
    motor_s = 1'b0;

    // Reset while the output is high
    chk("rst_pre_pwm", int'(pwm_out), 1);
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    chk("rst_mid_pwm", int'(pwm_out), 0);
    chk("rst_mid_level", int'(level), 0);
    step();
    chk("rst_after_pwm", int'(pwm_out), 0);

    // Settled-level vectors via scoreboard
    for (int k = 0; k < 18; k++) begin
      presencia_s = vecs[k].pres;
      motor_s = vecs[k].mot;
      strobe(vecs[k].temp);
      e.idx = k;
      e.lvl = vecs[k].lvl;
      e.highs = highs_for(vecs[k].lvl);
      sb.push_back(e);
      repeat (SETTLE) step();
      if (sb.size() == 0) begin
        chk($sformatf("vec%0d_sb_empty", k), 0, 1);
      end else begin
        e = sb.pop_front();
        chk($sformatf("vec%0d_level", e.idx), int'(level), e.lvl);
        count_highs(h);
        chk($sformatf("vec%0d_highs", e.idx), h, e.highs);
      end
    end
    motor_s = 1'b0;
    presencia_s = 1'b1;

    // Stale watchdog
    ka_en = 1'b0;
    repeat (24) step();
`ifdef FAN_CTRL_STALE_WDT_EN
    chk("wdt_fault_set", int'(fault), 1);
    chk("wdt_forced_high", int'(level), 3);
    strobe(20);
    chk("wdt_fault_clear", int'(fault), 0);
    ka_en = 1'b1;
    repeat (SETTLE) step();
    chk("wdt_descend_off", int'(level), 0);
`else
    chk("wdt_fault_tied0", int'(fault), 0);
    chk("wdt_level_hold", int'(level), 1);
    ka_en = 1'b1;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
